truth_table_sequencer: RTL

Sequencer that exhaustively exercises a 3-input single-output logic device (in1,in2,in3 -> out) across all 8 input rows. For each row it holds the inputs, waits a settle interval that models propagation or expression delay, and majority-samples the output. It assembles the measured 8-bit truth-table code in the team's hex convention and compares it against an expected code. It sits between a test or config host and the logic instance under evaluation.

---
 rtl/truth_table_sequencer_if.sv | 21 ++
 rtl/truth_table_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/truth_table_sequencer_if.sv
// Host-side bundle for truth_table_sequencer: run request, expected code and results.
// master = test/config host, slave = sequencer.
interface truth_table_sequencer_if;
    logic       start;
    logic [7:0] expected;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] table_out;
    logic [2:0] mismatch_row;

    modport master (
        output start, expected,
        input  busy, done, pass, table_out, mismatch_row
    );

    modport slave (
        input  start, expected,
        output busy, done, pass, table_out, mismatch_row
    );
endinterface

// File: rtl/truth_table_sequencer.sv
// Purpose: walks a 3-input device through rows 0..7, majority-samples its output, builds/compares the truth-table code.
// Latency: done at t+1+8*(SETTLE_CYCLES+SAMPLES) after start sampled at t; early stop at first bad row with TT_MISMATCH_STOP_EN.
// Backpressure: none; start is accepted only in IDLE and ignored otherwise (no queuing).
module truth_table_sequencer #(
    parameter int SETTLE_CYCLES = 16,
    parameter int SAMPLES       = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    truth_table_sequencer_if.slave host,
    output logic                   in1,
    output logic                   in2,
    output logic                   in3,
    input  logic                   dut_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [2:0]  SAMPLE_LAST = 3'(SAMPLES - 1);
    localparam logic [3:0]  MAJ_THRESH  = 4'(SAMPLES / 2);

    state_t      state_q, state_d;
    logic [2:0]  row_q;
    logic [15:0] settle_cnt;
    logic [2:0]  samp_cnt;
    logic [3:0]  ones_cnt;
    logic [7:0]  acc_q;
    logic [7:0]  exp_q;
    logic [7:0]  table_q;
    logic        pass_q;
    logic [2:0]  mm_q;

    logic        settle_last;
    logic        samp_last;
    logic [3:0]  ones_next;
    logic        row_bit;
    logic [7:0]  acc_next;
    logic [7:0]  diff;
    logic [2:0]  mm_next;
    logic        early_stop;
    logic        running;

    assign settle_last = (settle_cnt == SETTLE_LAST);
    assign samp_last   = (samp_cnt == SAMPLE_LAST);
    assign ones_next   = ones_cnt + {3'b000, dut_out};
    assign row_bit     = (ones_next > MAJ_THRESH);

`ifdef TT_MISMATCH_STOP_EN
    assign early_stop = (row_bit != exp_q[3'd7 - row_q]);
`else
    assign early_stop = 1'b0;
`endif

    // Row r lands in bit 7-r so that row 000 is the MSB of the hex code.
    always_comb begin
        acc_next                = acc_q;
        acc_next[3'd7 - row_q]  = row_bit;
    end

    // Lowest mismatching row is the most significant differing bit.
    assign diff = acc_next ^ exp_q;
    always_comb begin
        mm_next = 3'd0;
        casez (diff)
            8'b1???????: mm_next = 3'd0;
            8'b01??????: mm_next = 3'd1;
            8'b001?????: mm_next = 3'd2;
            8'b0001????: mm_next = 3'd3;
            8'b00001???: mm_next = 3'd4;
            8'b000001??: mm_next = 3'd5;
            8'b0000001?: mm_next = 3'd6;
            8'b00000001: mm_next = 3'd7;
            default:     mm_next = 3'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (host.start) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_last) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (samp_last) begin
                    state_d = ((row_q == 3'd7) || early_stop) ? FINISH : SETTLE;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q      <= 3'd0;
            settle_cnt <= 16'd0;
            samp_cnt   <= 3'd0;
            ones_cnt   <= 4'd0;
            acc_q      <= 8'h00;
            exp_q      <= 8'h00;
            table_q    <= 8'h00;
            pass_q     <= 1'b0;
            mm_q       <= 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (host.start) begin
                        exp_q      <= host.expected;
                        acc_q      <= 8'h00;
                        row_q      <= 3'd0;
                        settle_cnt <= 16'd0;
                        samp_cnt   <= 3'd0;
                        ones_cnt   <= 4'd0;
                    end
                end
                SETTLE: begin
                    settle_cnt <= settle_last ? 16'd0 : settle_cnt + 16'd1;
                end
                SAMPLE: begin
                    if (samp_last) begin
                        samp_cnt <= 3'd0;
                        ones_cnt <= 4'd0;
                        acc_q    <= acc_next;
                        row_q    <= row_q + 3'd1;
                        // Results become visible in the FINISH cycle itself.
                        if (state_d == FINISH) begin
                            table_q <= acc_next;
                            pass_q  <= (acc_next == exp_q);
                            mm_q    <= mm_next;
                        end
                    end else begin
                        samp_cnt <= samp_cnt + 3'd1;
                        ones_cnt <= ones_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign running           = (state_q == SETTLE) || (state_q == SAMPLE);
    assign {in1, in2, in3}   = running ? row_q : 3'b000;
    assign host.busy         = running;
    assign host.done         = (state_q == FINISH);
    assign host.pass         = pass_q;
    assign host.table_out    = table_q;
    assign host.mismatch_row = mm_q;

endmodule
